asyc_fifo_read_ctrl: RTL and testbench
======================================

// Module: asyc_fifo_read_ctrl
// PURPOSE
//   Read-side controller of the async FIFO; sits entirely in the read clock domain.
//   - Owns the read pointer and drives read_addr into the dual-port FIFO RAM.
//   - Synchronises the write-domain Gray pointer into the read clock domain.
//   - Generates a registered empty flag.
//   - Exports its Gray read pointer so the write side can derive write_full.
// PARAMETERS
//   ADDR_WIDTH           6   RAM address width; FIFO depth = 2**ADDR_WIDTH
//   SYNC_STAGES          2   flops in the write_ptr_gray synchroniser chain (>=2)
//   ALMOST_EMPTY_THRESH  4   level at/below which read_almost_empty asserts (macro only)
// PORTS
//   read_clk           in   1             read-domain clock
//   read_rst_n         in   1             asynchronous, active-low reset
//   read_ena           in   1             pop request from consumer
//   write_ptr_gray     in   ADDR_WIDTH+1  write pointer, Gray code, write-clock domain
//   read_addr          out  ADDR_WIDTH    RAM read address (head of FIFO)
//   read_ptr_gray      out  ADDR_WIDTH+1  registered Gray read pointer, to write domain
//   read_empty         out  1             FIFO empty, registered
//   read_level         out  ADDR_WIDTH+1  occupancy seen by read side (macro only)
//   read_almost_empty  out  1             read_level <= ALMOST_EMPTY_THRESH (macro only)
// BEHAVIOUR
//   - Reset (async assert, sync release on read_clk):
//       rptr_bin = 0, read_ptr_gray = 0, read_addr = 0, sync chain = 0,
//       read_empty = 1, read_level = 0, read_almost_empty = 1.
//   - Pointers: rptr_bin is ADDR_WIDTH+1 bits. The extra MSB is the wrap bit.
//       read_addr = rptr_bin[ADDR_WIDTH-1:0].
//       read_ptr_gray = registered (rptr_bin_next ^ (rptr_bin_next >> 1)).
//   - Pop: accepted iff read_ena && !read_empty.
//       Accepted pop: rptr_bin += 1, modulo 2**(ADDR_WIDTH+1).
//       read_ena while read_empty = 1 is ignored: no pointer change, no error.
//   - Data timing: the RAM read is combinational on read_addr.
//       read_data is valid in any cycle where read_empty = 0.
//       The consumer samples read_data in the same cycle it asserts read_ena.
//   - Synchroniser: SYNC_STAGES-flop chain on write_ptr_gray. Gray code only; no binary crosses.
//   - Empty: read_empty <= (rptr_gray_next == wptr_gray_sync), registered.
//       A pop of the last entry asserts read_empty on the following edge; there are no bubbles.
//   - Latency: a write_ptr_gray change sampled at edge k deasserts read_empty at edge k+SYNC_STAGES.
//       This is pessimistic and safe; empty never deasserts early.
//   - Wrap-around:
//       read_addr rolls 2**ADDR_WIDTH-1 -> 0.
//       The MSB toggles each full lap.
//       Empty equality covers all ADDR_WIDTH+1 bits, so there is no lap aliasing.
//   - Simultaneous pop and write-pointer update: both take effect in the same edge.
//       Empty is computed from rptr_gray_next and the current sync output.
//   - Reset mid-operation: everything returns to reset values immediately.
//       The write side must be reset in the same system reset event.
// CONFIGURATION
//   ASYC_FIFO_RD_LEVEL_EN defined:
//     - The read_level and read_almost_empty ports exist.
//     - Each cycle, wptr_gray_sync is Gray-to-binary converted.
//     - read_level <= (wptr_bin_sync - rptr_bin_next) mod 2**(ADDR_WIDTH+1), registered.
//     - read_almost_empty <= (that level <= ALMOST_EMPTY_THRESH), registered.
//   ASYC_FIFO_RD_LEVEL_EN undefined:
//     - Those ports and that logic are absent.
//     - All other behaviour is identical.
// TESTING (ADDR_WIDTH=6, SYNC_STAGES=2)
//   1. Reset: pulse read_rst_n low mid-clock.
//      -> read_empty=1, read_addr=0, read_ptr_gray=0 immediately, with no clock.
//   2. Sync latency: write_ptr_gray 0->1 before edge k.
//      -> read_empty=1 through edge k+1; read_empty=0 after edge k+2.
//   3. Underflow: hold read_ena=1 with write_ptr_gray=0 for 10 cycles.
//      -> read_addr stays 0, read_ptr_gray stays 0, read_empty stays 1.
//   4. Drain: write_ptr_gray=0x03 (2 entries), then read_ena=1 for 3 cycles.
//      -> read_addr 0,1,2; read_empty=1 after the 2nd pop; the 3rd pop is ignored.
//   5. Wrap: stream 64 then 128 pops, write pointer kept ahead.
//      -> read_addr 63->0; read_ptr_gray=0x60 at 64 pops; 0x00 at 128 pops.
//   6. Level (macro on): write_ptr_gray=0x0F (10 entries), rptr=0.
//      -> read_level=10, read_almost_empty=0 after sync.
//      -> After 6 pops: read_level=4, read_almost_empty=1.

Source files
------------

// File: rtl/asyc_fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : asyc_fifo_read_ctrl_if
// Brief    : Bundle between the async FIFO read controller and its consumer.
//            Level signals exist only when ASYC_FIFO_RD_LEVEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface asyc_fifo_read_ctrl_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  read_ena;
    logic [ADDR_WIDTH:0]   write_ptr_gray;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH:0]   read_ptr_gray;
    logic                  read_empty;
`ifdef ASYC_FIFO_RD_LEVEL_EN
    logic [ADDR_WIDTH:0]   read_level;
    logic                  read_almost_empty;

    modport master (
        output read_ena, write_ptr_gray,
        input  read_addr, read_ptr_gray, read_empty, read_level, read_almost_empty
    );
    modport slave (
        input  read_ena, write_ptr_gray,
        output read_addr, read_ptr_gray, read_empty, read_level, read_almost_empty
    );
`else
    modport master (
        output read_ena, write_ptr_gray,
        input  read_addr, read_ptr_gray, read_empty
    );
    modport slave (
        input  read_ena, write_ptr_gray,
        output read_addr, read_ptr_gray, read_empty
    );
`endif
endinterface
`default_nettype wire

// File: rtl/asyc_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : asyc_fifo_read_ctrl
// Brief    : Read-domain controller of the async FIFO: read pointer, Gray
//            write-pointer synchroniser and registered empty flag.
//            Optional level / almost-empty under ASYC_FIFO_RD_LEVEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module asyc_fifo_read_ctrl #(
    parameter int ADDR_WIDTH  = 6,
    parameter int SYNC_STAGES = 2
`ifdef ASYC_FIFO_RD_LEVEL_EN
    ,
    parameter int ALMOST_EMPTY_THRESH = 4
`endif
) (
    input  wire logic            read_clk,
    input  wire logic            read_rst_n,
    asyc_fifo_read_ctrl_if.slave rd_if
);
    localparam int c_PW = ADDR_WIDTH + 1;

    logic [c_PW-1:0]                  r_rptr_bin;
    logic [c_PW-1:0]                  r_rptr_gray;
    logic                             r_empty;
    logic [SYNC_STAGES-1:0][c_PW-1:0] r_sync;

    logic            w_pop;
    logic [c_PW-1:0] w_rptr_bin_next;
    logic [c_PW-1:0] w_rptr_gray_next;
    logic [c_PW-1:0] w_wptr_gray_sync;

    always_comb begin
        w_pop            = rd_if.read_ena && !r_empty;
        w_rptr_bin_next  = r_rptr_bin + c_PW'(w_pop);
        w_rptr_gray_next = w_rptr_bin_next ^ (w_rptr_bin_next >> 1);
    end

    assign w_wptr_gray_sync = r_sync[SYNC_STAGES-1];

    // Empty compares the full wrap-bit Gray pointers, so laps never alias.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_sync      <= '0;
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
            r_empty     <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], rd_if.write_ptr_gray};
            r_rptr_bin  <= w_rptr_bin_next;
            r_rptr_gray <= w_rptr_gray_next;
            r_empty     <= (w_rptr_gray_next == w_wptr_gray_sync);
        end
    end

    assign rd_if.read_addr     = r_rptr_bin[ADDR_WIDTH-1:0];
    assign rd_if.read_ptr_gray = r_rptr_gray;
    assign rd_if.read_empty    = r_empty;

`ifdef ASYC_FIFO_RD_LEVEL_EN
    localparam logic [c_PW-1:0] c_THRESH = c_PW'(ALMOST_EMPTY_THRESH);

    logic [c_PW-1:0] w_wptr_bin_sync;
    logic [c_PW-1:0] w_level_next;
    logic [c_PW-1:0] r_level;
    logic            r_almost_empty;

    always_comb begin
        w_wptr_bin_sync         = '0;
        w_wptr_bin_sync[c_PW-1] = w_wptr_gray_sync[c_PW-1];
        for (int i = c_PW - 2; i >= 0; i--) begin
            w_wptr_bin_sync[i] = w_wptr_bin_sync[i+1] ^ w_wptr_gray_sync[i];
        end
        w_level_next = w_wptr_bin_sync - w_rptr_bin_next;
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_level        <= '0;
            r_almost_empty <= 1'b1;
        end else begin
            r_level        <= w_level_next;
            r_almost_empty <= (w_level_next <= c_THRESH);
        end
    end

    assign rd_if.read_level        = r_level;
    assign rd_if.read_almost_empty = r_almost_empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_asyc_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_asyc_fifo_read_ctrl
// Brief    : Self-checking bench for asyc_fifo_read_ctrl (ADDR_WIDTH=6,
//            SYNC_STAGES=2); level checks under ASYC_FIFO_RD_LEVEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asyc_fifo_read_ctrl;
    localparam int c_AW   = 6;
    localparam int c_MOD  = 128;
    localparam int c_SYNC = 2;

    logic read_clk;
    logic read_rst_n;

    asyc_fifo_read_ctrl_if #(.ADDR_WIDTH(c_AW)) rd_if ();

    asyc_fifo_read_ctrl #(
        .ADDR_WIDTH (c_AW),
        .SYNC_STAGES(c_SYNC)
    ) dut (
        .read_clk  (read_clk),
        .read_rst_n(read_rst_n),
        .rd_if     (rd_if)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        int b = 0;
        for (int v = g; v != 0; v = v >> 1) b = b ^ v;
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Reference: occupancy arithmetic on binary counts; the write pointer is
    // seen by the read side as the value sampled c_SYNC edges earlier.
    int m_rptr;
    bit m_empty;
    int m_level;
    bit m_ae;
    int m_hist [c_SYNC];

    always @(posedge read_clk or negedge read_rst_n) begin
        int nxt, seen;
        if (!read_rst_n) begin
            m_rptr  = 0;
            m_empty = 1;
            m_level = 0;
            m_ae    = 1;
            for (int i = 0; i < c_SYNC; i++) m_hist[i] = 0;
        end else begin
            seen    = g2b(m_hist[c_SYNC-1]);
            nxt     = (m_rptr + ((rd_if.read_ena && !m_empty) ? 1 : 0)) % c_MOD;
            m_level = (seen - nxt + c_MOD) % c_MOD;
            m_empty = (m_level == 0);
            m_ae    = (m_level <= 4);
            for (int i = c_SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(rd_if.write_ptr_gray);
            m_rptr    = nxt;
        end
    end

    always @(negedge read_clk) begin
        if (read_rst_n) begin
            check("cmp_addr",  int'(rd_if.read_addr),     m_rptr % 64);
            check("cmp_gray",  int'(rd_if.read_ptr_gray), gray(m_rptr));
            check("cmp_empty", int'(rd_if.read_empty),    int'(m_empty));
`ifdef ASYC_FIFO_RD_LEVEL_EN
            check("cmp_level", int'(rd_if.read_level),        m_level);
            check("cmp_ae",    int'(rd_if.read_almost_empty), int'(m_ae));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge read_clk);
        #1;
    endtask

    // Reset asserted mid-cycle; outputs must clear without any clock edge.
    task automatic do_reset(input bit chk);
        @(posedge read_clk);
        #3;
        read_rst_n           = 1'b0;
        rd_if.read_ena       = 1'b0;
        rd_if.write_ptr_gray = '0;
        #1;
        if (chk) begin
            check("rst_empty", int'(rd_if.read_empty),    1);
            check("rst_addr",  int'(rd_if.read_addr),     0);
            check("rst_gray",  int'(rd_if.read_ptr_gray), 0);
        end
        #1 read_rst_n = 1'b1;
    endtask

    int wcount;

    initial begin
        read_rst_n           = 1'b0;
        rd_if.read_ena       = 1'b0;
        rd_if.write_ptr_gray = '0;
        #12 read_rst_n = 1'b1;

        // Advance the pointer a little, then reset mid-operation
        tick(1);
        rd_if.write_ptr_gray = 7'(gray(5));
        tick(4);
        rd_if.read_ena = 1'b1;
        tick(3);
        do_reset(1'b1);

        // Synchroniser latency
        tick(1);
        rd_if.write_ptr_gray = 7'd1;
        tick(1);
        check("lat_k",   int'(rd_if.read_empty), 1);
        tick(1);
        check("lat_k1",  int'(rd_if.read_empty), 1);
        tick(1);
        check("lat_k2",  int'(rd_if.read_empty), 0);

        // Underflow
        do_reset(1'b0);
        tick(1);
        rd_if.read_ena = 1'b1;
        tick(10);
        check("uf_addr",  int'(rd_if.read_addr),     0);
        check("uf_gray",  int'(rd_if.read_ptr_gray), 0);
        check("uf_empty", int'(rd_if.read_empty),    1);

        // Drain two entries with three pop requests
        do_reset(1'b0);
        tick(1);
        rd_if.write_ptr_gray = 7'h03;
        tick(3);
        check("dr_addr0",  int'(rd_if.read_addr),  0);
        check("dr_empty0", int'(rd_if.read_empty), 0);
        rd_if.read_ena = 1'b1;
        tick(1);
        check("dr_addr1",  int'(rd_if.read_addr),  1);
        check("dr_empty1", int'(rd_if.read_empty), 0);
        tick(1);
        check("dr_addr2",  int'(rd_if.read_addr),  2);
        check("dr_empty2", int'(rd_if.read_empty), 1);
        tick(1);
        check("dr_addr3",  int'(rd_if.read_addr),  2);
        check("dr_empty3", int'(rd_if.read_empty), 1);
        rd_if.read_ena = 1'b0;

        // Wrap: 128 back-to-back pops with the writer 32 entries ahead
        do_reset(1'b0);
        tick(1);
        wcount = 32;
        rd_if.write_ptr_gray = 7'(gray(wcount));
        tick(3);
        rd_if.read_ena = 1'b1;
        for (int i = 1; i <= 128; i++) begin
            tick(1);
            wcount = (wcount + 1) % c_MOD;
            rd_if.write_ptr_gray = 7'(gray(wcount));
            if (i == 63) check("wr_addr63", int'(rd_if.read_addr), 63);
            if (i == 64) begin
                check("wr_addr64", int'(rd_if.read_addr),     0);
                check("wr_gray64", int'(rd_if.read_ptr_gray), 'h60);
            end
            if (i == 128) begin
                check("wr_addr128", int'(rd_if.read_addr),     0);
                check("wr_gray128", int'(rd_if.read_ptr_gray), 'h00);
            end
        end
        rd_if.read_ena = 1'b0;

`ifdef ASYC_FIFO_RD_LEVEL_EN
        // Level and almost-empty
        do_reset(1'b0);
        tick(1);
        rd_if.write_ptr_gray = 7'h0F;
        tick(3);
        check("lv_level10", int'(rd_if.read_level),        10);
        check("lv_ae10",    int'(rd_if.read_almost_empty), 0);
        rd_if.read_ena = 1'b1;
        tick(6);
        rd_if.read_ena = 1'b0;
        check("lv_level4", int'(rd_if.read_level),        4);
        check("lv_ae4",    int'(rd_if.read_almost_empty), 1);
`endif

        // Randomised traffic against the reference
        do_reset(1'b0);
        wcount = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick(1);
            if (cyc == 1500) begin
                #2;
                read_rst_n           = 1'b0;
                wcount               = 0;
                rd_if.write_ptr_gray = '0;
                #1 read_rst_n = 1'b1;
            end else begin
                rd_if.read_ena = ($urandom_range(0, 99) < 60);
                if (((wcount - m_rptr + c_MOD) % c_MOD) < 64 && $urandom_range(0, 99) < 55)
                    wcount = (wcount + 1) % c_MOD;
                rd_if.write_ptr_gray = 7'(gray(wcount));
            end
        end
        rd_if.read_ena = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
